// File: rtl/addsub_limb_seq_if.sv
// Bundles the request, adder and result signals of the multi-limb add/sub sequencer.
// ADDSUB_LIMB_SEQ_OVF_EN adds the res_ovf_o overflow flag.
interface addsub_limb_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LIMBS  = 4,
  parameter int CNT_W      = $clog2(MAX_LIMBS + 1)
);
  logic                            req_valid_i;
  logic                            req_ready_o;
  logic                            req_sub_i;
  logic [CNT_W-1:0]                req_limbs_i;
  logic [MAX_LIMBS*DATA_WIDTH-1:0] req_a_i;
  logic [MAX_LIMBS*DATA_WIDTH-1:0] req_b_i;
  logic                            add_en_o;
  logic [DATA_WIDTH-1:0]           add_a_o;
  logic [DATA_WIDTH-1:0]           add_b_o;
  logic                            add_ci_o;
  logic                            add_sub_o;
  logic [DATA_WIDTH-1:0]           add_sum_i;
  logic                            add_co_i;
  logic                            res_valid_o;
  logic                            res_ready_i;
  logic [MAX_LIMBS*DATA_WIDTH-1:0] res_data_o;
  logic                            res_co_o;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
  logic                            res_ovf_o;

  modport slave (
    input  req_valid_i, req_sub_i, req_limbs_i, req_a_i, req_b_i,
    input  add_sum_i, add_co_i, res_ready_i,
    output req_ready_o, add_en_o, add_a_o, add_b_o, add_ci_o, add_sub_o,
    output res_valid_o, res_data_o, res_co_o, res_ovf_o
  );
  modport master (
    output req_valid_i, req_sub_i, req_limbs_i, req_a_i, req_b_i,
    output add_sum_i, add_co_i, res_ready_i,
    input  req_ready_o, add_en_o, add_a_o, add_b_o, add_ci_o, add_sub_o,
    input  res_valid_o, res_data_o, res_co_o, res_ovf_o
  );
`else
  modport slave (
    input  req_valid_i, req_sub_i, req_limbs_i, req_a_i, req_b_i,
    input  add_sum_i, add_co_i, res_ready_i,
    output req_ready_o, add_en_o, add_a_o, add_b_o, add_ci_o, add_sub_o,
    output res_valid_o, res_data_o, res_co_o
  );
  modport master (
    output req_valid_i, req_sub_i, req_limbs_i, req_a_i, req_b_i,
    output add_sum_i, add_co_i, res_ready_i,
    input  req_ready_o, add_en_o, add_a_o, add_b_o, add_ci_o, add_sub_o,
    input  res_valid_o, res_data_o, res_co_o
  );
`endif
endinterface

// File: rtl/addsub_limb_seq.sv
// Multi-limb add/sub sequencer: feeds a single-limb adder LSB limb first, chaining carry/borrow.
// Optional ADDSUB_LIMB_SEQ_OVF_EN adds a signed-overflow flag for the top active limb.
//
// state | meaning
// IDLE  | ready for a request, adder gated
// RUN   | one limb per cycle through the adder
// DONE  | result held until consumer accepts
module addsub_limb_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LIMBS  = 4,
  parameter int CNT_W      = $clog2(MAX_LIMBS + 1)
) (
  input logic           module_clk_i,
  input logic           module_rst_i,
  addsub_limb_seq_if.slave bus
);
  localparam int IDX_W = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_q   [MAX_LIMBS];
  logic [DATA_WIDTH-1:0] b_q   [MAX_LIMBS];
  logic [DATA_WIDTH-1:0] res_q [MAX_LIMBS];
  logic [IDX_W-1:0]      idx_q, last_q, last_d, idx_nx;
  logic [DATA_WIDTH-1:0] add_a_q, add_b_q;
  logic                  add_en_q, add_ci_q, add_sub_q;
  logic                  req_ready_q, res_valid_q, res_co_q;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
  logic                  ovf_q, ovf_d;
`endif

  // Zero behaves as one limb, anything beyond MAX_LIMBS as MAX_LIMBS.
  always_comb begin
    if (bus.req_limbs_i == '0)
      last_d = '0;
    else if (bus.req_limbs_i > CNT_W'(MAX_LIMBS))
      last_d = IDX_W'(MAX_LIMBS - 1);
    else
      last_d = IDX_W'(bus.req_limbs_i - 1'b1);
  end

  assign idx_nx = idx_q + 1'b1;

`ifdef ADDSUB_LIMB_SEQ_OVF_EN
  always_comb begin
    if (add_sub_q)
      ovf_d = (add_a_q[DATA_WIDTH-1] != add_b_q[DATA_WIDTH-1]) &&
              (bus.add_sum_i[DATA_WIDTH-1] != add_a_q[DATA_WIDTH-1]);
    else
      ovf_d = (add_a_q[DATA_WIDTH-1] == add_b_q[DATA_WIDTH-1]) &&
              (bus.add_sum_i[DATA_WIDTH-1] != add_a_q[DATA_WIDTH-1]);
  end
`endif

  always_ff @(posedge module_clk_i or posedge module_rst_i) begin
    if (module_rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_en_q    <= 1'b0;
      add_ci_q    <= 1'b0;
      add_sub_q   <= 1'b0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_co_q    <= 1'b0;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
      for (int i = 0; i < MAX_LIMBS; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            for (int i = 0; i < MAX_LIMBS; i++) begin
              a_q[i]   <= bus.req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
              b_q[i]   <= bus.req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
              res_q[i] <= '0;
            end
            last_q      <= last_d;
            idx_q       <= '0;
            add_sub_q   <= bus.req_sub_i;
            add_en_q    <= 1'b1;
            add_a_q     <= bus.req_a_i[DATA_WIDTH-1:0];
            add_b_q     <= bus.req_b_i[DATA_WIDTH-1:0];
            add_ci_q    <= 1'b0;
            res_co_q    <= 1'b0;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
            req_ready_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          res_q[idx_q] <= bus.add_sum_i;
          if (idx_q == last_q) begin
            res_co_q    <= bus.add_co_i;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
            add_en_q    <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q    <= idx_nx;
            add_a_q  <= a_q[idx_nx];
            add_b_q  <= b_q[idx_nx];
            add_ci_q <= bus.add_co_i;
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.add_en_o    = add_en_q;
  assign bus.add_a_o     = add_a_q;
  assign bus.add_b_o     = add_b_q;
  assign bus.add_ci_o    = add_ci_q;
  assign bus.add_sub_o   = add_sub_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_co_o    = res_co_q;
`ifdef ADDSUB_LIMB_SEQ_OVF_EN
  assign bus.res_ovf_o   = ovf_q;
`endif

  for (genvar g = 0; g < MAX_LIMBS; g++) begin : g_res
    assign bus.res_data_o[g*DATA_WIDTH +: DATA_WIDTH] = res_q[g];
  end
endmodule
